// File: rtl/tl_mem_responder.sv
// ============================================================================
// Module   : tl_mem_responder
// Brief    : Single-outstanding TileLink-style memory responder (Get / PutFullData)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tl_mem_responder #(
  parameter logic [1:0] REGION = 2'b01,
  parameter int         DEPTH  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        a_valid_i,
  output logic        a_ready_o,
  input  logic [2:0]  a_opcode_i,
  input  logic [11:0] a_address_i,
  input  logic [31:0] a_data_i,
  output logic        d_valid_o,
  input  logic        d_ready_i,
  output logic [2:0]  d_opcode_o,
  output logic [31:0] d_data_o,
  output logic        d_error_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  localparam logic [2:0] OP_GET   = 3'b100;
  localparam logic [2:0] OP_PUT   = 3'b000;
  localparam logic [2:0] OP_ACK   = 3'b000;
  localparam logic [2:0] OP_ACKD  = 3'b001;

  logic [1:0]  r_state;
  logic [2:0]  r_opcode;
  logic [11:0] r_addr;
  logic [31:0] r_wdata;
  logic [2:0]  r_d_opcode;
  logic [31:0] r_d_data;
  logic        r_d_error;
  logic [31:0] r_mem [DEPTH];

  logic          w_hs;
  logic [9:0]    w_index;
  logic [AW-1:0] w_mem_idx;
  logic          w_hit;
  logic          w_get;
  logic          w_put;
  logic          w_resp;

  assign w_hs      = a_valid_i & a_ready_o;
  assign w_index   = r_addr[9:0];
  assign w_mem_idx = w_index[AW-1:0];
  // Out-of-range indices are folded into the region-mismatch error path.
  assign w_hit     = (r_addr[11:10] == REGION) && ({22'd0, w_index} < 32'(DEPTH));
  assign w_get     = w_hit && (r_opcode == OP_GET);
  assign w_put     = w_hit && (r_opcode == OP_PUT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_opcode   <= 3'd0;
      r_addr     <= 12'd0;
      r_wdata    <= 32'd0;
      r_d_opcode <= 3'd0;
      r_d_data   <= 32'd0;
      r_d_error  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_opcode <= a_opcode_i;
            r_addr   <= a_address_i;
            r_wdata  <= a_data_i;
            r_state  <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          r_d_opcode <= w_get ? OP_ACKD : OP_ACK;
          r_d_data   <= w_get ? r_mem[w_mem_idx] : 32'd0;
          r_d_error  <= !(w_get || w_put);
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (d_ready_i) begin
            r_d_opcode <= 3'd0;
            r_d_data   <= 32'd0;
            r_d_error  <= 1'b0;
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Storage is deliberately outside the reset domain so contents survive reset;
  // an asserted reset already forces IDLE, which blocks any pending write.
  always_ff @(posedge clk) begin
    if ((r_state == S_ACCESS) && w_put) begin
      r_mem[w_mem_idx] <= r_wdata;
    end
  end

  assign w_resp     = (r_state == S_RESP);
  assign a_ready_o  = reset && (r_state == S_IDLE);
  assign d_valid_o  = w_resp;
  assign d_opcode_o = w_resp ? r_d_opcode : 3'd0;
  assign d_data_o   = w_resp ? r_d_data   : 32'd0;
  assign d_error_o  = w_resp ? r_d_error  : 1'b0;

endmodule

`default_nettype wire
